ps2_bcd_entry: RTL

//  Sequential successor to the combinational scan-code-to-BCD decoder.
//  - Consumes PS/2 set-2 scan-code bytes from the PS/2 receiver.
//  - Filters break (F0) and extended (E0) prefixes.
//  - Accumulates up to N_DIGITS decimal keys into a packed-BCD entry register.
//  - Supports backspace, escape and enter; enter latches the entry for downstream consumers.

---
 rtl/ps2_bcd_entry.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ps2_bcd_entry.sv
// PS/2 set-2 scan-code keypad entry: filters break/extended prefixes and
// accumulates decimal keys into a packed-BCD register, latched on enter.
module ps2_bcd_entry #(
  parameter int unsigned N_DIGITS  = 4,
  parameter bit          KEYPAD_EN = 1'b1,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_done_tick,
  input  logic [7:0]              ps2_data,
  input  logic                    clr,
  output logic [4*N_DIGITS-1:0]   entry,
  output logic [CNT_W-1:0]        digit_count,
  output logic [4*N_DIGITS-1:0]   bcd_value,
  output logic                    done_tick,
  output logic                    digit_tick,
  output logic                    ovf_tick
);

  localparam int unsigned EW = 4 * N_DIGITS;

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBksp  = 8'h66;
  localparam logic [7:0] CodeEsc   = 8'h76;
  localparam logic [7:0] CodeEnter = 8'h5A;

  typedef enum logic [1:0] {StIdle, StBrk, StExt} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [EW-1:0]     bcd_q, bcd_d;
  logic              done_q, done_d;
  logic              digit_q, digit_d;
  logic              ovf_q, ovf_d;

  logic              is_digit;
  logic [3:0]        digit_val;
  logic              do_digit, do_bksp, do_esc, do_enter;

  // Scan-code to digit map; keypad codes only when enabled.
  always_comb begin
    is_digit  = 1'b1;
    digit_val = 4'h0;
    unique case (ps2_data)
      8'h45: digit_val = 4'd0;
      8'h16: digit_val = 4'd1;
      8'h1E: digit_val = 4'd2;
      8'h26: digit_val = 4'd3;
      8'h25: digit_val = 4'd4;
      8'h2E: digit_val = 4'd5;
      8'h36: digit_val = 4'd6;
      8'h3D: digit_val = 4'd7;
      8'h3E: digit_val = 4'd8;
      8'h46: digit_val = 4'd9;
      8'h70: begin digit_val = 4'd0; is_digit = KEYPAD_EN; end
      8'h69: begin digit_val = 4'd1; is_digit = KEYPAD_EN; end
      8'h72: begin digit_val = 4'd2; is_digit = KEYPAD_EN; end
      8'h7A: begin digit_val = 4'd3; is_digit = KEYPAD_EN; end
      8'h6B: begin digit_val = 4'd4; is_digit = KEYPAD_EN; end
      8'h73: begin digit_val = 4'd5; is_digit = KEYPAD_EN; end
      8'h74: begin digit_val = 4'd6; is_digit = KEYPAD_EN; end
      8'h6C: begin digit_val = 4'd7; is_digit = KEYPAD_EN; end
      8'h75: begin digit_val = 4'd8; is_digit = KEYPAD_EN; end
      8'h7D: begin digit_val = 4'd9; is_digit = KEYPAD_EN; end
      default: is_digit = 1'b0;
    endcase
  end

  // Prefix-filter FSM: decides which action (if any) the strobed byte triggers.
  always_comb begin
    state_d  = state_q;
    do_digit = 1'b0;
    do_bksp  = 1'b0;
    do_esc   = 1'b0;
    do_enter = 1'b0;
    if (clr) begin
      state_d = StIdle;
    end else if (rx_done_tick) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_data == CodeBreak) begin
            state_d = StBrk;
          end else if (ps2_data == CodeExt) begin
            state_d = StExt;
          end else if (is_digit) begin
            do_digit = 1'b1;
          end else if (ps2_data == CodeBksp) begin
            do_bksp = 1'b1;
          end else if (ps2_data == CodeEsc) begin
            do_esc = 1'b1;
          end else if (ps2_data == CodeEnter) begin
            do_enter = 1'b1;
          end
        end
        StBrk: state_d = StIdle;
        StExt: begin
          if (ps2_data == CodeBreak) begin
            state_d = StBrk;
          end else begin
            state_d  = StIdle;
            do_enter = (ps2_data == CodeEnter);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    digit_d = 1'b0;
    ovf_d   = 1'b0;
    if (clr) begin
      entry_d = '0;
      count_d = '0;
    end else if (do_digit) begin
      if (count_q < CNT_W'(N_DIGITS)) begin
        entry_d = {entry_q[EW-5:0], digit_val};
        count_d = count_q + CNT_W'(1);
        digit_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (do_bksp) begin
      if (count_q != '0) begin
        entry_d = {4'h0, entry_q[EW-1:4]};
        count_d = count_q - CNT_W'(1);
      end
    end else if (do_esc) begin
      entry_d = '0;
      count_d = '0;
    end else if (do_enter) begin
      bcd_d   = entry_q;
      done_d  = 1'b1;
      entry_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      entry_q <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      digit_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
    end
  end

  assign entry       = entry_q;
  assign digit_count = count_q;
  assign bcd_value   = bcd_q;
  assign done_tick   = done_q;
  assign digit_tick  = digit_q;
  assign ovf_tick    = ovf_q;

endmodule
